apb_multi_slave_bridge: RTL
===========================

APB_MULTI_SLAVE_BRIDGE -- requirements
Module: apb_multi_slave_bridge

Interface
REQ-001 Parameter ADDR_W, 32, APB address width; the top SEL_W = clog2(N_SLV) bits form the slave index.
REQ-002 Parameter DATA_W, 32, PWDATA/PRDATA width.
REQ-003 Parameter N_SLV, 4, number of APB slaves (2..16; need not be a power of two).
REQ-004 Parameter TIMEOUT, 16, maximum ACCESS cycles before abort (>=2).
REQ-005 The bridge SHALL use one clock; reset is asynchronous and active-low; ports are named PCLK and PRESETn.
REQ-006 PCLK  in  1  clock, all logic on rising edge.
REQ-007 PRESETn  in  1  asynchronous active-low reset.
REQ-008 cmd_valid  in  1  host request present.
REQ-009 cmd_ready  out  1  bridge can accept a request.
REQ-010 cmd_write  in  1  1 = write, 0 = read.
REQ-011 cmd_addr  in  ADDR_W  target address.
REQ-012 cmd_wdata  in  DATA_W  write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  slave error, timeout or unmapped address.
REQ-016 PSEL  out  N_SLV  one-hot slave select.
REQ-017 PENABLE, PWRITE  out  1 each  APB access phase, direction.
REQ-018 PADDR  out  ADDR_W; PWDATA  out  DATA_W.
REQ-019 PRDATA  in  N_SLV*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W].
REQ-020 PREADY, PSLVERR  in  N_SLV each  per-slave ready and error.

Function
REQ-021 FSM states SHALL be IDLE, SETUP, ACCESS and ERR.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid & cmd_ready.
REQ-023 On a handshake, cmd_write, cmd_addr and cmd_wdata SHALL be registered onto PWRITE, PADDR and PWDATA.
REQ-024 On a handshake the FSM SHALL move to SETUP if the index is < N_SLV, else to ERR.
REQ-025 In SETUP: exactly PSEL[index] = 1, PENABLE = 0; the FSM moves to ACCESS unconditionally after one cycle.
REQ-026 In ACCESS: PSEL held, PENABLE = 1; PADDR, PWDATA and PWRITE are stable from SETUP through ACCESS.
REQ-027 Only PREADY[index], PSLVERR[index] and PRDATA slice[index] SHALL be observed; other slaves are ignored.
REQ-028 On ACCESS with PREADY[index] = 1: PSEL and PENABLE drop; next cycle rsp_valid = 1, rsp_err = PSLVERR[index], rsp_rdata = slice on reads (0 on writes); the FSM returns to IDLE.
REQ-029 A wait-state counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY = 0.
REQ-030 When the counter reaches TIMEOUT-1 with PREADY still 0, the bridge SHALL drop PSEL/PENABLE and pulse rsp_valid next cycle with rsp_err = 1 and rsp_rdata = 0.
REQ-031 ERR (unmapped address) SHALL assert no PSEL and last one cycle; rsp_valid with rsp_err = 1 and rdata 0 follows next cycle; ERR then returns to IDLE.
REQ-032 Zero-wait latency: handshake at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3.
REQ-033 The rsp_valid cycle SHALL coincide with IDLE, so a new handshake may occur in that same cycle (back-to-back).
REQ-034 Responses SHALL have no backpressure; the host must accept rsp_valid.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 Asserting PRESETn low SHALL immediately set state IDLE, PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, counter = 0, and cmd_ready = 1 after release.
REQ-037 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid.

Structure
REQ-038 Package apb_bridge_pkg SHALL hold the state enum and clog2-derived SEL_W helpers.
REQ-039 Sub-module apb_addr_decoder (combinational: addr -> index, in_range, one-hot select) SHALL be instantiated once.

Verification
REQ-040 Zero-wait write to slave 2 (addr 0x8000_0010, data 0xDEAD_BEEF, N_SLV=4) -> PSEL = 4'b0100 at T+1..T+2, PENABLE at T+2, rsp_valid at T+3, rsp_err = 0.
REQ-041 Read from slave 1 with 3 wait states, PRDATA1 = 0x1234_5678 -> rsp_valid at T+6, rsp_rdata = 0x1234_5678; other slices = 0xFFFF_FFFF are ignored.
REQ-042 Slave never ready, TIMEOUT = 16 -> PSEL drops after 16 ACCESS cycles, rsp_err = 1, rsp_rdata = 0.
REQ-043 N_SLV = 3, addr index 3 -> PSEL stays 0, rsp_valid at T+2 with rsp_err = 1.
REQ-044 PSLVERR[0] = 1 with PREADY on a write -> rsp_err = 1; a back-to-back command issued in the rsp cycle is accepted.
REQ-045 PRESETn low mid-ACCESS -> PSEL and PENABLE go 0 asynchronously, no rsp_valid, cmd_ready = 1 after release.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and width helpers for the APB multi-slave bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    // Slave-index width taken from the top of the address.
    function automatic int unsigned sel_width(input int unsigned n_slv);
        return (n_slv < 2) ? 1 : $clog2(n_slv);
    endfunction

    // Wait-state counter width; must hold TIMEOUT-1.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational decode of the address index field into slave index, range flag and one-hot select.
module apb_addr_decoder #(
    parameter int unsigned N_SLV = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0] addr_hi,
    output logic [SEL_W-1:0] index_c,
    output logic             in_range_c,
    output logic [N_SLV-1:0] sel_c
);

    always_comb begin
        index_c    = addr_hi;
        in_range_c = (32'(addr_hi) < N_SLV);
        sel_c      = '0;
        if (in_range_c) begin
            sel_c[addr_hi] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// Host command to APB bridge fanning out to N_SLV slaves selected by the top address bits.
module apb_multi_slave_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_SLV   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [N_SLV-1:0]        PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_W-1:0]       PADDR,
    output logic [DATA_W-1:0]       PWDATA,
    input  logic [N_SLV*DATA_W-1:0] PRDATA,
    input  logic [N_SLV-1:0]        PREADY,
    input  logic [N_SLV-1:0]        PSLVERR
);

    localparam int unsigned SEL_W = sel_width(N_SLV);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    state_e state, state_n;

    logic [SEL_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [N_SLV-1:0]  psel_n;
    logic              penable_n, pwrite_n, cmd_ready_n, rsp_valid_n, rsp_err_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n, rsp_rdata_n;

    logic [SEL_W-1:0]  dec_idx_c;
    logic              dec_in_range_c;
    logic [N_SLV-1:0]  dec_sel_c;
    logic              pready_c, pslverr_c;
    logic [DATA_W-1:0] prdata_c;

    apb_addr_decoder #(
        .N_SLV (N_SLV),
        .SEL_W (SEL_W)
    ) u_dec (
        .addr_hi    (cmd_addr[ADDR_W-1 -: SEL_W]),
        .index_c    (dec_idx_c),
        .in_range_c (dec_in_range_c),
        .sel_c      (dec_sel_c)
    );

    // Only the addressed slave's handshake and data are ever looked at.
    assign pready_c  = PREADY[idx];
    assign pslverr_c = PSLVERR[idx];
    assign prdata_c  = PRDATA[32'(idx)*DATA_W +: DATA_W];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        psel_n      = PSEL;
        penable_n   = PENABLE;
        pwrite_n    = PWRITE;
        paddr_n     = PADDR;
        pwdata_n    = PWDATA;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_n = cmd_write;
                    paddr_n  = cmd_addr;
                    pwdata_n = cmd_wdata;
                    idx_n    = dec_idx_c;
                    if (dec_in_range_c) begin
                        psel_n  = dec_sel_c;
                        state_n = ST_SETUP;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
            end
            ST_SETUP: begin
                penable_n = 1'b1;
                cnt_n     = '0;
                state_n   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_c) begin
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = pslverr_c;
                    rsp_rdata_n = PWRITE ? '0 : prdata_c;
                    state_n     = ST_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Slave stalled too long: abandon and report an error.
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    state_n     = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_ERR: begin
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
                state_n     = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        cmd_ready_n = (state_n == ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx       <= '0;
            cnt       <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            idx       <= idx_n;
            cnt       <= cnt_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            PWRITE    <= pwrite_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

endmodule
